// File: rtl/atm_ctrl_multi_if.sv
// Session bus for the multi-account ATM controller: customer-side strobes in,
// account result and session status out.
interface atm_ctrl_multi_if #(
  parameter int DATA_W = 16
) ();

  logic              card_inserted;
  logic              language_selection_enable;
  logic              lang_sel;
  logic [DATA_W-1:0] userPassword;
  logic              pin_valid;
  logic [1:0]        OpSelector;
  logic              op_valid;
  logic [DATA_W-1:0] amount;
  logic              amt_valid;
  logic              anotherSelctor;
  logic [DATA_W-1:0] atm_output;
  logic [2:0]        status;
  logic              done;
  logic              lang_o;
  logic              session_active;

  modport master (
    output card_inserted, language_selection_enable, lang_sel, userPassword, pin_valid,
           OpSelector, op_valid, amount, amt_valid, anotherSelctor,
    input  atm_output, status, done, lang_o, session_active
  );

  modport slave (
    input  card_inserted, language_selection_enable, lang_sel, userPassword, pin_valid,
           OpSelector, op_valid, amount, amt_valid, anotherSelctor,
    output atm_output, status, done, lang_o, session_active
  );

endinterface

// File: rtl/atm_ctrl_multi.sv
// Multi-account ATM session controller: card/language/PIN login with lockout,
// then withdraw/deposit/balance operations on a resettable balance bank.
module atm_ctrl_multi #(
  parameter int DATA_W    = 16,
  parameter int NUM_USERS = 7,
  parameter int BASE_ID   = 1000,
  parameter int INIT_BAL  = 500,
  parameter int WD_LIMIT  = 5000,
  parameter int MAX_TRIES = 3
) (
  input logic               clk,
  input logic               rst,
  atm_ctrl_multi_if.slave   bus
);

  localparam int AcctW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
  localparam int TryW  = $clog2(MAX_TRIES + 1);

  localparam logic [DATA_W-1:0] PinLo    = DATA_W'(BASE_ID);
  localparam logic [DATA_W-1:0] PinHi    = DATA_W'(BASE_ID + NUM_USERS - 1);
  localparam logic [DATA_W-1:0] WdLimit  = DATA_W'(WD_LIMIT);
  localparam logic [DATA_W-1:0] InitBal  = DATA_W'(INIT_BAL);
  localparam logic [TryW-1:0]   MaxTries = TryW'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE, LANG, PIN, MENU, AMOUNT, EXEC, RESULT, LOCK
  } stateT;

  typedef enum logic [1:0] {
    OP_NONE     = 2'b00,
    OP_WITHDRAW = 2'b01,
    OP_DEPOSIT  = 2'b10,
    OP_BALANCE  = 2'b11
  } opT;

  typedef enum logic [2:0] {
    ST_OK         = 3'd0,
    ST_BAD_PIN    = 3'd1,
    ST_LOCKED     = 3'd2,
    ST_NO_FUNDS   = 3'd3,
    ST_OVER_LIMIT = 3'd4,
    ST_OVERFLOW   = 3'd5
  } statusT;

  stateT              state, stateNext;
  opT                 op, opNext;
  statusT             statusReg, statusNext;
  logic [AcctW-1:0]   acct, acctNext;
  logic [DATA_W-1:0]  amt, amtNext;
  logic [TryW-1:0]    tries, triesNext, triesInc;
  logic [DATA_W-1:0]  atmOut, atmOutNext;
  logic               lang, langNext;
  logic               done, doneNext;
  logic               sessionActive, sessionActiveNext;

  logic [DATA_W-1:0]  bal [NUM_USERS];
  logic [DATA_W-1:0]  curBal;
  logic [DATA_W:0]    depSum;
  logic               balWe;
  logic [DATA_W-1:0]  balWdata;
  logic               abort;
  logic               pinOk;

  assign curBal   = bal[acct];
  assign depSum   = {1'b0, curBal} + {1'b0, amt};
  assign triesInc = tries + 1'b1;
  assign abort    = (state != IDLE) && !bus.card_inserted;
  assign pinOk    = (bus.userPassword >= PinLo) && (bus.userPassword <= PinHi);

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    stateNext  = state;
    opNext     = op;
    statusNext = statusReg;
    acctNext   = acct;
    amtNext    = amt;
    triesNext  = tries;
    atmOutNext = atmOut;
    langNext   = lang;
    balWe      = 1'b0;
    balWdata   = curBal;

    case (state)
      IDLE: begin
        if (bus.card_inserted) begin
          stateNext  = LANG;
          triesNext  = '0;
          statusNext = ST_OK;
          atmOutNext = '0;
        end
      end

      LANG: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (bus.language_selection_enable) begin
          langNext  = bus.lang_sel;
          stateNext = PIN;
        end
      end

      PIN: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (bus.pin_valid) begin
          if (pinOk) begin
            acctNext   = AcctW'(bus.userPassword - PinLo);
            statusNext = ST_OK;
            stateNext  = MENU;
          end else begin
            triesNext  = triesInc;
            statusNext = ST_BAD_PIN;
            if (triesInc == MaxTries) begin
              statusNext = ST_LOCKED;
              stateNext  = LOCK;
            end
          end
        end
      end

      MENU: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (bus.op_valid) begin
          case (opT'(bus.OpSelector))
            OP_BALANCE: begin
              atmOutNext = curBal;
              statusNext = ST_OK;
              stateNext  = RESULT;
            end
            OP_WITHDRAW, OP_DEPOSIT: begin
              opNext    = opT'(bus.OpSelector);
              stateNext = AMOUNT;
            end
            default: ;
          endcase
        end
      end

      AMOUNT: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (bus.amt_valid) begin
          amtNext   = bus.amount;
          stateNext = EXEC;
        end
      end

      // The commit happens even if the card is pulled now: the op was accepted.
      EXEC: begin
        stateNext  = abort ? IDLE : RESULT;
        atmOutNext = curBal;
        if (op == OP_WITHDRAW) begin
          if (amt > WdLimit) begin
            statusNext = ST_OVER_LIMIT;
          end else if (amt > curBal) begin
            statusNext = ST_NO_FUNDS;
          end else begin
            balWe      = 1'b1;
            balWdata   = curBal - amt;
            atmOutNext = curBal - amt;
            statusNext = ST_OK;
          end
        end else begin
          if (depSum[DATA_W]) begin
            statusNext = ST_OVERFLOW;
          end else begin
            balWe      = 1'b1;
            balWdata   = depSum[DATA_W-1:0];
            atmOutNext = depSum[DATA_W-1:0];
            statusNext = ST_OK;
          end
        end
      end

      RESULT: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (bus.anotherSelctor) begin
          stateNext = MENU;
        end
      end

      LOCK: begin
        if (abort) stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase

    doneNext          = (stateNext == RESULT) && (state != RESULT);
    sessionActiveNext = (stateNext == MENU) || (stateNext == AMOUNT) ||
                        (stateNext == EXEC) || (stateNext == RESULT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op            <= OP_NONE;
      statusReg     <= ST_OK;
      acct          <= '0;
      amt           <= '0;
      tries         <= '0;
      atmOut        <= '0;
      lang          <= 1'b1;
      done          <= 1'b0;
      sessionActive <= 1'b0;
    end else begin
      state         <= stateNext;
      op            <= opNext;
      statusReg     <= statusNext;
      acct          <= acctNext;
      amt           <= amtNext;
      tries         <= triesNext;
      atmOut        <= atmOutNext;
      lang          <= langNext;
      done          <= doneNext;
      sessionActive <= sessionActiveNext;
    end
  end

  // NOTE: the balance bank is a handful of flops, not a RAM macro, so it can
  // and must take a reset value; a real SRAM would need an init sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_USERS; i++) bal[i] <= InitBal;
    end else if (balWe) begin
      bal[acct] <= balWdata;
    end
  end

  assign bus.atm_output     = atmOut;
  assign bus.status         = statusReg;
  assign bus.done           = done;
  assign bus.lang_o         = lang;
  assign bus.session_active = sessionActive;

endmodule
